// File: rtl/line_clear.sv
// Removes every completely filled row from a placed board, one row examined per clock,
// shifting the rows above down and keeping a saturating running count of cleared lines.
module line_clear #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int CNT_W   = 5,
    parameter int TOT_W   = 16
) (
    input  logic                       main_clk,
    input  logic                       rst_1plus,
    input  logic                       start,
    input  logic [BOARD_W*BOARD_H-1:0] board_in,
    output logic                       busy,
    output logic                       done,
    output logic [BOARD_W*BOARD_H-1:0] board_out,
    output logic [CNT_W-1:0]           lines_cleared,
    output logic [TOT_W-1:0]           total_lines
);

    localparam int unsigned BW = BOARD_W * BOARD_H;
    localparam int unsigned H  = BOARD_H;
    localparam int unsigned W  = BOARD_W;
    localparam int          RW = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [BW-1:0]    work;
    logic [BW-1:0]    shifted;
    logic [RW-1:0]    r;
    logic [CNT_W-1:0] n;
    logic             row_full;
    logic             last_row;
    logic [TOT_W:0]   tot_sum;
    int unsigned      r_idx;

    // Rows below r are kept, rows above r drop by one, the top row becomes empty.
    always_comb begin
        r_idx    = 32'(r);
        row_full = 1'b0;
        shifted  = '0;
        for (int unsigned k = 0; k < H; k++) begin
            if (k == r_idx) begin
                row_full = &work[k*W +: W];
            end
            if (k < r_idx) begin
                shifted[k*W +: W] = work[k*W +: W];
            end else if (k < H - 1) begin
                shifted[k*W +: W] = work[(k+1)*W +: W];
            end
        end
    end

    always_comb begin
        last_row = (r == RW'(BOARD_H - 1));
        tot_sum  = {1'b0, total_lines} + (TOT_W+1)'(n);
        busy     = (state == SCAN) || (state == DONE);
        done     = (state == DONE);
    end

    always_ff @(posedge main_clk or posedge rst_1plus) begin
        if (rst_1plus) begin
            state         <= IDLE;
            work          <= '0;
            r             <= '0;
            n             <= '0;
            board_out     <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= board_in;
                        r     <= '0;
                        n     <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        // r stays put so the row that just dropped into place is tested next
                        work <= shifted;
                        n    <= n + 1'b1;
                    end else if (!last_row) begin
                        r <= r + 1'b1;
                    end else begin
                        state         <= DONE;
                        board_out     <= work;
                        lines_cleared <= n;
                        total_lines   <= tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
